// File: rtl/line_draw_engine.sv
// line_draw_engine: Bresenham line rasteriser pushing one two-beat burst per pixel into the DRAM request FIFOs.
// Define LE_CLIP_EN to skip pixels outside HRES x VRES instead of letting the address wrap.
module line_draw_engine #(
   parameter int HRES = 800,
   parameter int VRES = 600
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  LE_color,
   input  logic [19:0]  LE_point,
   input  logic         LE_color_valid,
   input  logic         LE_point0_valid,
   input  logic         LE_point1_valid,
   input  logic         LE_trigger,
   input  logic [31:0]  LE_frame,
   output logic         LE_ready,
   input  logic         af_full,
   input  logic         wdf_full,
   output logic         af_wr_en,
   output logic [30:0]  af_addr_din,
   output logic         wdf_wr_en,
   output logic [127:0] wdf_din,
   output logic [15:0]  wdf_mask_din
);
`ifdef LE_CLIP_EN
   localparam logic CLIP_EN = 1'b1;
`else
   localparam logic CLIP_EN = 1'b0;
`endif
   localparam logic [9:0] HMAX = 10'(HRES);
   localparam logic [9:0] VMAX = 10'(VRES);
   typedef enum logic [1:0] {IDLE, SETUP, WR_A, WR_B} state_t;
   state_t state_q, state_d;
   logic [23:0] color_q, color_d;
   logic [27:0] frame_q, frame_d;
   logic [19:0] p0_q, p0_d, p1_q, p1_d;
   logic [9:0] x_q, x_d, y_q, y_d, x1_q, x1_d;
   logic [10:0] dx_q, dx_d, dy_q, dy_d;
   logic [11:0] err_q, err_d, err_s;
   logic steep_q, steep_d, yneg_q, yneg_d;
   logic [9:0] adx, ady, ax0, ay0, ax1, ay1, sx0, sy0, sx1, sy1, px, py;
   logic steep, swap, clip, go_a, go_b, step;
   logic [27:0] pix;
   logic [15:0] mask;
   logic unused_bits;

   assign unused_bits = ^{LE_color[31:24], LE_frame[31:30], LE_frame[1:0]};

   always_comb begin
      adx = (p1_q[19:10] > p0_q[19:10]) ? p1_q[19:10] - p0_q[19:10] : p0_q[19:10] - p1_q[19:10];
      ady = (p1_q[9:0] > p0_q[9:0]) ? p1_q[9:0] - p0_q[9:0] : p0_q[9:0] - p1_q[9:0];
      steep = ady > adx;
      ax0 = steep ? p0_q[9:0] : p0_q[19:10];
      ay0 = steep ? p0_q[19:10] : p0_q[9:0];
      ax1 = steep ? p1_q[9:0] : p1_q[19:10];
      ay1 = steep ? p1_q[19:10] : p1_q[9:0];
      swap = ax0 > ax1;
      sx0 = swap ? ax1 : ax0;
      sy0 = swap ? ay1 : ay0;
      sx1 = swap ? ax0 : ax1;
      sy1 = swap ? ay0 : ay1;
      px = steep_q ? y_q : x_q;
      py = steep_q ? x_q : y_q;
      pix = frame_q + {8'b0, py, px};
      mask = ~(16'hF << {pix[1:0], 2'b00});
      clip = CLIP_EN && (px >= HMAX || py >= VMAX);
      go_a = state_q == WR_A && !clip && !af_full && !wdf_full;
      go_b = state_q == WR_B && !wdf_full;
      step = go_b || (state_q == WR_A && clip);
      err_s = err_q - {1'b0, dy_q};
   end

   always_comb begin
      state_d = state_q;
      color_d = color_q;
      frame_d = frame_q;
      p0_d = p0_q;
      p1_d = p1_q;
      x_d = x_q;
      y_d = y_q;
      x1_d = x1_q;
      dx_d = dx_q;
      dy_d = dy_q;
      err_d = err_q;
      steep_d = steep_q;
      yneg_d = yneg_q;
      if (state_q == IDLE) begin
         color_d = LE_color_valid ? LE_color[23:0] : color_q;
         p0_d = LE_point0_valid ? LE_point : p0_q;
         p1_d = LE_point1_valid ? LE_point : p1_q;
         frame_d = LE_trigger ? LE_frame[29:2] : frame_q;
         state_d = LE_trigger ? SETUP : IDLE;
      end
      if (state_q == SETUP) begin
         steep_d = steep;
         x_d = sx0;
         y_d = sy0;
         x1_d = sx1;
         dx_d = {1'b0, sx1 - sx0};
         dy_d = {1'b0, (sy1 > sy0) ? sy1 - sy0 : sy0 - sy1};
         err_d = {2'b0, sx1 - sx0} >> 1;
         yneg_d = sy0 >= sy1;
         state_d = WR_A;
      end
      if (go_a)
         state_d = WR_B;
      // Last pixel done when x reaches the far endpoint; otherwise advance one Bresenham step.
      if (step) begin
         if (x_q == x1_q)
            state_d = IDLE;
         else begin
            state_d = WR_A;
            x_d = x_q + 10'd1;
            y_d = err_s[11] ? (yneg_q ? y_q - 10'd1 : y_q + 10'd1) : y_q;
            err_d = err_s[11] ? err_s + {1'b0, dx_q} : err_s;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         color_q <= '0;
         frame_q <= '0;
         p0_q <= '0;
         p1_q <= '0;
         x_q <= '0;
         y_q <= '0;
         x1_q <= '0;
         dx_q <= '0;
         dy_q <= '0;
         err_q <= '0;
         steep_q <= 1'b0;
         yneg_q <= 1'b0;
      end else begin
         state_q <= state_d;
         color_q <= color_d;
         frame_q <= frame_d;
         p0_q <= p0_d;
         p1_q <= p1_d;
         x_q <= x_d;
         y_q <= y_d;
         x1_q <= x1_d;
         dx_q <= dx_d;
         dy_q <= dy_d;
         err_q <= err_d;
         steep_q <= steep_d;
         yneg_q <= yneg_d;
      end
   end

   assign LE_ready = state_q == IDLE;
   assign af_wr_en = go_a;
   assign wdf_wr_en = go_a || go_b;
   assign af_addr_din = (state_q == WR_A) ? {3'b0, pix[27:3], 3'b000} : '0;
   assign wdf_din = (state_q == WR_A || state_q == WR_B) ? {4{8'h00, color_q}} : '0;
   assign wdf_mask_din = ((state_q == WR_A && !pix[2]) || (state_q == WR_B && pix[2])) ? mask : 16'hFFFF;
endmodule

// File: tb/tb_line_draw_engine.sv
// tb_line_draw_engine: directed and random lines under random FIFO back-pressure,
// checked against a textbook Bresenham reference model.
module tb_line_draw_engine;
`ifdef LE_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [31:0] LE_color = '0, LE_frame = '0;
   logic [19:0] LE_point = '0;
   logic LE_color_valid = 1'b0, LE_point0_valid = 1'b0, LE_point1_valid = 1'b0, LE_trigger = 1'b0;
   logic af_full = 1'b0, wdf_full = 1'b0;
   logic LE_ready, af_wr_en, wdf_wr_en;
   logic [30:0] af_addr_din;
   logic [127:0] wdf_din;
   logic [15:0] wdf_mask_din;
   int n_cmp = 0, n_bad = 0;
   logic [30:0] got_addr[$];
   logic [143:0] got_beat[$];
   logic [30:0] exp_addr[$];
   logic [15:0] exp_m0[$], exp_m1[$];
   logic [23:0] cur_color = '0;
   int exp_cyc;

   always #5 clk = ~clk;

   line_draw_engine dut (
      .clk(clk), .rst(rst), .LE_color(LE_color), .LE_point(LE_point),
      .LE_color_valid(LE_color_valid), .LE_point0_valid(LE_point0_valid),
      .LE_point1_valid(LE_point1_valid), .LE_trigger(LE_trigger), .LE_frame(LE_frame),
      .LE_ready(LE_ready), .af_full(af_full), .wdf_full(wdf_full), .af_wr_en(af_wr_en),
      .af_addr_din(af_addr_din), .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return v < 0 ? -v : v;
   endfunction

   always @(negedge clk) begin
      if (af_wr_en) begin
         chk("af_en_while_full", 128'(af_full), 128'd0);
         chk("af_without_wdf", 128'(wdf_wr_en), 128'd1);
         got_addr.push_back(af_addr_din);
      end
      if (wdf_wr_en) begin
         chk("wdf_en_while_full", 128'(wdf_full), 128'd0);
         got_beat.push_back({wdf_mask_din, wdf_din});
      end
   end

   task automatic model(input int ax0, input int ay0, input int ax1, input int ay1, input logic [31:0] frame);
      int x0 = ax0, y0 = ay0, x1 = ax1, y1 = ay1, t, dx, dy, err, ys, y, px, py;
      bit steep;
      logic [27:0] p;
      logic [15:0] m;
      exp_addr.delete();
      exp_m0.delete();
      exp_m1.delete();
      exp_cyc = 1;
      steep = iabs(y1 - y0) > iabs(x1 - x0);
      if (steep) begin
         t = x0; x0 = y0; y0 = t;
         t = x1; x1 = y1; y1 = t;
      end
      if (x0 > x1) begin
         t = x0; x0 = x1; x1 = t;
         t = y0; y0 = y1; y1 = t;
      end
      dx = x1 - x0;
      dy = iabs(y1 - y0);
      err = dx / 2;
      ys = (y0 < y1) ? 1 : -1;
      y = y0;
      for (int x = x0; x <= x1; x++) begin
         px = steep ? y : x;
         py = steep ? x : y;
         if (CLIP && (px >= 800 || py >= 600))
            exp_cyc += 1;
         else begin
            p = frame[29:2] + 28'(py * 1024 + px);
            m = 16'hFFFF;
            m[4 * p[1:0] +: 4] = 4'h0;
            exp_addr.push_back({3'b0, p[27:3], 3'b000});
            exp_m0.push_back(p[2] ? 16'hFFFF : m);
            exp_m1.push_back(p[2] ? m : 16'hFFFF);
            exp_cyc += 2;
         end
         err -= dy;
         if (err < 0) begin
            y += ys;
            err += dx;
         end
      end
   endtask

   task automatic draw(input logic [31:0] color, input bit load_color, input int x0, input int y0,
                       input int x1, input int y1, input logic [31:0] frame, input int stall, input string name);
      int low = 0;
      bit done = 0;
      logic [127:0] data;
      if (load_color) cur_color = color[23:0];
      model(x0, y0, x1, y1, frame);
      data = {4{8'h00, cur_color}};
      got_addr.delete();
      got_beat.delete();
      @(posedge clk); #1;
      LE_color = color;
      LE_color_valid = load_color;
      LE_point = {10'(x0), 10'(y0)};
      LE_point0_valid = 1'b1;
      @(posedge clk); #1;
      LE_color_valid = 1'b0;
      LE_point0_valid = 1'b0;
      LE_point = {10'(x1), 10'(y1)};
      LE_point1_valid = 1'b1;
      LE_trigger = 1'b1;
      LE_frame = frame;
      while (!done && low < 5000) begin
         @(posedge clk); #1;
         LE_color = $urandom;
         LE_point = 20'($urandom);
         LE_frame = $urandom;
         LE_color_valid = !LE_ready;
         LE_point0_valid = !LE_ready && $urandom_range(0, 1) == 1;
         LE_point1_valid = !LE_ready && $urandom_range(0, 1) == 1;
         LE_trigger = !LE_ready && $urandom_range(0, 1) == 1;
         af_full = (stall == 1) ? ($urandom_range(0, 3) == 0) : (stall == 2 && low >= 3 && low < 13);
         wdf_full = (stall == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
         @(negedge clk);
         if (LE_ready) done = 1;
         else low++;
      end
      af_full = 1'b0;
      wdf_full = 1'b0;
      LE_color_valid = 1'b0;
      LE_point0_valid = 1'b0;
      LE_point1_valid = 1'b0;
      LE_trigger = 1'b0;
      chk({name, "_done"}, 128'(done), 128'd1);
      if (stall == 0) chk({name, "_busy_cycles"}, 128'(low), 128'(exp_cyc));
      chk({name, "_bursts"}, 128'(got_addr.size()), 128'(exp_addr.size()));
      chk({name, "_beats"}, 128'(got_beat.size()), 128'(2 * exp_addr.size()));
      for (int i = 0; i < exp_addr.size(); i++) begin
         if (i < got_addr.size()) chk({name, "_addr"}, 128'(got_addr[i]), 128'(exp_addr[i]));
         if (2 * i + 1 < got_beat.size()) begin
            chk({name, "_b0_data"}, got_beat[2 * i][127:0], data);
            chk({name, "_b0_mask"}, 128'(got_beat[2 * i][143:128]), 128'(exp_m0[i]));
            chk({name, "_b1_data"}, got_beat[2 * i + 1][127:0], data);
            chk({name, "_b1_mask"}, 128'(got_beat[2 * i + 1][143:128]), 128'(exp_m1[i]));
         end
      end
   endtask

   initial begin
      logic [15:0] t1m[4] = '{16'hFFF0, 16'hFF0F, 16'hF0FF, 16'h0FFF};
      int x0, y0, x1, y1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 128'(LE_ready), 128'd1);
      chk("rst_af_en", 128'(af_wr_en), 128'd0);
      chk("rst_wdf_en", 128'(wdf_wr_en), 128'd0);
      chk("rst_addr", 128'(af_addr_din), 128'd0);
      chk("rst_din", wdf_din, 128'd0);
      chk("rst_mask", 128'(wdf_mask_din), 128'hFFFF);
      rst = 1'b1;

      draw(32'h00FF0000, 1, 0, 0, 3, 0, 32'h10400000, 0, "t1");
      if (got_addr.size() == 4 && got_beat.size() == 8)
         for (int i = 0; i < 4; i++) begin
            chk("t1_const_addr", 128'(got_addr[i]), 128'h4100000);
            chk("t1_const_m0", 128'(got_beat[2 * i][143:128]), 128'(t1m[i]));
            chk("t1_const_m1", 128'(got_beat[2 * i + 1][143:128]), 128'hFFFF);
         end
      draw(32'h0, 0, 0, 0, 1, 3, 32'h10400000, 0, "t2");
      draw(32'h0012ABCD, 1, 3, 0, 0, 0, 32'h10400000, 0, "t3");
      draw(32'hFF00FF00, 1, 5, 5, 5, 5, 32'h10400000, 0, "t4");
      if (got_addr.size() == 1 && got_beat.size() == 2) begin
         chk("t4_const_addr", 128'(got_addr[0]), 128'h4101400);
         chk("t4_const_m0", 128'(got_beat[0][143:128]), 128'hFFFF);
         chk("t4_const_m1", 128'(got_beat[1][143:128]), 128'hFF0F);
      end
      draw(32'h00345678, 1, 0, 0, 20, 7, 32'h20000000, 2, "t5");
      draw(32'h00ABCDEF, 1, 798, 0, 801, 0, 32'h10400000, 0, "t6");
      if (CLIP) chk("t6_clip_bursts", 128'(got_addr.size()), 128'd2);

      @(posedge clk); #1;
      LE_point = {10'd0, 10'd0};
      LE_point0_valid = 1'b1;
      @(posedge clk); #1;
      LE_point0_valid = 1'b0;
      LE_point = {10'd100, 10'd0};
      LE_point1_valid = 1'b1;
      LE_trigger = 1'b1;
      @(posedge clk); #1;
      LE_point1_valid = 1'b0;
      LE_trigger = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("midline_busy", 128'(LE_ready), 128'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midline_rst_ready", 128'(LE_ready), 128'd1);
      chk("midline_rst_af_en", 128'(af_wr_en), 128'd0);
      chk("midline_rst_wdf_en", 128'(wdf_wr_en), 128'd0);
      chk("midline_rst_mask", 128'(wdf_mask_din), 128'hFFFF);
      rst = 1'b1;
      cur_color = '0;

      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            x0 = $urandom_range(770, 830);
            y0 = $urandom_range(570, 630);
         end else begin
            x0 = $urandom_range(0, 1023);
            y0 = $urandom_range(0, 1023);
         end
         x1 = x0 + $urandom_range(0, 80) - 40;
         y1 = y0 + $urandom_range(0, 80) - 40;
         x1 = x1 < 0 ? 0 : (x1 > 1023 ? 1023 : x1);
         y1 = y1 < 0 ? 0 : (y1 > 1023 ? 1023 : y1);
         draw($urandom, $urandom_range(0, 1) == 1, x0, y0, x1, y1, $urandom, $urandom_range(0, 1), "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
